// File: rtl/ps2_ascii_source_if.sv
// Keyboard-side bundle of ps2_ascii_source: the raw PS/2 lines in, and the
// decoded key level, strobes and status out.
interface ps2_ascii_source_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] ascii;
  logic       key_pulse;
  logic [7:0] scan_code;
  logic       code_valid;
  logic       frame_err;
  logic       caps_led;

  modport master (
    input  ps2_clk, ps2_data,
    output ascii, key_pulse, scan_code, code_valid, frame_err, caps_led
  );

  modport slave (
    output ps2_clk, ps2_data,
    input  ascii, key_pulse, scan_code, code_valid, frame_err, caps_led
  );
endinterface

// File: rtl/ps2_ascii_source.sv
// PS/2 set-2 keyboard receiver and decoder: presents the ASCII code of the held
// key as a level (zero after release) for the text terminal's typematic logic.
module ps2_ascii_source #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               reset,
  ps2_ascii_source_if.master bus
);

  typedef enum logic [1:0] {F_IDLE, F_DATA, F_PARITY, F_STOP} frame_state_t;
  typedef enum logic [1:0] {D_NORM, D_BRK, D_EXT, D_EXT_BRK} dec_state_t;

  localparam logic [15:0] TIMEOUT = 16'(TIMEOUT_CYCLES);

  logic         clk_sync_p0, clk_sync_p1, clk_prev_p2;
  logic         data_sync_p0, data_sync_p1;
  logic         fall;
  logic [15:0]  idle_cnt;
  frame_state_t fstate;
  logic [2:0]   bit_cnt;
  logic [7:0]   shreg;
  logic         par_ok;
  logic [7:0]   scan_code;
  logic         code_valid, frame_err;
  dec_state_t   dstate;
  logic         lshift, rshift, caps_led, caps_held;
  logic [7:0]   ascii, held_code;
  logic         key_pulse;
  logic [7:0]   make_ascii;

  // Returns 0 for any code without a printable/editing mapping.
  function automatic logic [7:0] map_ascii(input logic [7:0] code,
                                           input logic shift, input logic caps);
    logic [7:0] lc;
    logic [7:0] r;
    lc = 8'h00;
    r  = 8'h00;
    case (code)
      8'h1C: lc = "a";  8'h32: lc = "b";  8'h21: lc = "c";  8'h23: lc = "d";
      8'h24: lc = "e";  8'h2B: lc = "f";  8'h34: lc = "g";  8'h33: lc = "h";
      8'h43: lc = "i";  8'h3B: lc = "j";  8'h42: lc = "k";  8'h4B: lc = "l";
      8'h3A: lc = "m";  8'h31: lc = "n";  8'h44: lc = "o";  8'h4D: lc = "p";
      8'h15: lc = "q";  8'h2D: lc = "r";  8'h1B: lc = "s";  8'h2C: lc = "t";
      8'h3C: lc = "u";  8'h2A: lc = "v";  8'h1D: lc = "w";  8'h22: lc = "x";
      8'h35: lc = "y";  8'h1A: lc = "z";
      default: lc = 8'h00;
    endcase
    if (lc != 8'h00) begin
      r = (shift ^ caps) ? lc - 8'h20 : lc;
    end else begin
      case (code)
        8'h45: r = shift ? ")" : "0";
        8'h16: r = shift ? "!" : "1";
        8'h1E: r = shift ? "@" : "2";
        8'h26: r = shift ? "#" : "3";
        8'h25: r = shift ? "$" : "4";
        8'h2E: r = shift ? "%" : "5";
        8'h36: r = shift ? "^" : "6";
        8'h3D: r = shift ? "&" : "7";
        8'h3E: r = shift ? "*" : "8";
        8'h46: r = shift ? "(" : "9";
        8'h29: r = 8'h20;
        8'h5A: r = 8'h0D;
        8'h66: r = 8'h08;
        8'h4E: r = shift ? "_" : "-";
        8'h41: r = shift ? "<" : ",";
        8'h49: r = shift ? ">" : ".";
        8'h4A: r = shift ? "?" : "/";
        default: r = 8'h00;
      endcase
    end
    return r;
  endfunction

  // Stage p0/p1: synchronizers, p2: falling-edge detect of the keyboard clock
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_p0  <= 1'b1;
      clk_sync_p1  <= 1'b1;
      clk_prev_p2  <= 1'b1;
      data_sync_p0 <= 1'b1;
      data_sync_p1 <= 1'b1;
      fall         <= 1'b0;
    end else begin
      clk_sync_p0  <= bus.ps2_clk;
      clk_sync_p1  <= clk_sync_p0;
      clk_prev_p2  <= clk_sync_p1;
      data_sync_p0 <= bus.ps2_data;
      data_sync_p1 <= data_sync_p0;
      fall         <= clk_prev_p2 & ~clk_sync_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || fall)              idle_cnt <= 16'd0;
    else if (idle_cnt != 16'hFFFF)  idle_cnt <= idle_cnt + 16'd1;
  end

  // Frame stage: start/data/parity/stop, result visible the cycle after the stop edge
  always_ff @(posedge clk) begin
    if (reset) begin
      fstate     <= F_IDLE;
      bit_cnt    <= 3'd0;
      par_ok     <= 1'b0;
      scan_code  <= 8'h00;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fstate != F_IDLE && idle_cnt == TIMEOUT) begin
        fstate    <= F_IDLE;
        frame_err <= 1'b1;
      end else if (fall) begin
        case (fstate)
          F_IDLE: begin
            if (!data_sync_p1) begin
              fstate  <= F_DATA;
              bit_cnt <= 3'd0;
            end
          end
          F_DATA: begin
            shreg   <= {data_sync_p1, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) fstate <= F_PARITY;
          end
          F_PARITY: begin
            par_ok <= ^{shreg, data_sync_p1};
            fstate <= F_STOP;
          end
          default: begin
            if (data_sync_p1 && par_ok) begin
              scan_code  <= shreg;
              code_valid <= 1'b1;
            end else begin
              frame_err  <= 1'b1;
            end
            fstate <= F_IDLE;
          end
        endcase
      end
    end
  end

  assign make_ascii = map_ascii(scan_code, lshift | rshift, caps_led);

  // Decode stage: prefixes, modifiers and held-key level, one cycle after code_valid
  always_ff @(posedge clk) begin
    if (reset) begin
      dstate    <= D_NORM;
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      caps_led  <= 1'b0;
      caps_held <= 1'b0;
      ascii     <= 8'h00;
      held_code <= 8'h00;
      key_pulse <= 1'b0;
    end else begin
      key_pulse <= 1'b0;
      if (code_valid) begin
        case (dstate)
          D_NORM: begin
            if (scan_code == 8'hF0) begin
              dstate <= D_BRK;
            end else if (scan_code == 8'hE0) begin
              dstate <= D_EXT;
            end else if (!(scan_code inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF})) begin
              if (scan_code == 8'h12) lshift <= 1'b1;
              if (scan_code == 8'h59) rshift <= 1'b1;
              if (scan_code == 8'h58 && !caps_held) begin
                caps_led  <= ~caps_led;
                caps_held <= 1'b1;
              end
              if (make_ascii != 8'h00) begin
                ascii     <= make_ascii;
                held_code <= scan_code;
                key_pulse <= 1'b1;
              end
            end
          end
          D_BRK: begin
            if (scan_code == 8'h12) lshift    <= 1'b0;
            if (scan_code == 8'h59) rshift    <= 1'b0;
            if (scan_code == 8'h58) caps_held <= 1'b0;
            if (scan_code == held_code) begin
              ascii     <= 8'h00;
              held_code <= 8'h00;
            end
            dstate <= D_NORM;
          end
          D_EXT:   dstate <= (scan_code == 8'hF0) ? D_EXT_BRK : D_NORM;
          default: dstate <= D_NORM;
        endcase
      end
    end
  end

  assign bus.ascii      = ascii;
  assign bus.key_pulse  = key_pulse;
  assign bus.scan_code  = scan_code;
  assign bus.code_valid = code_valid;
  assign bus.frame_err  = frame_err;
  assign bus.caps_led   = caps_led;

endmodule

// File: tb/tb_ps2_ascii_source.sv
// Bench for ps2_ascii_source: bit-bangs PS/2 frames and checks received bytes,
// strobes and the held-key level against expectations set at stimulus time.
module tb_ps2_ascii_source;
  localparam int TO = 300;
  localparam int H  = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;

  ps2_ascii_source_if bus();

  ps2_ascii_source #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];
  int         err_exp = 0;
  int         kp_cnt = 0;
  int         cv_cnt = 0;
  int         err_cnt = 0;
  longint     cyc = 0;
  longint     cv_cyc = -10;
  logic       kp_prev = 1'b0;

  // Scoreboard: every received byte / error strobe must have been announced
  always @(negedge clk) begin
    if (bus.code_valid) begin
      cv_cnt++;
      cv_cyc = cyc;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL code_valid_unexpected scan_code=%h expected none", bus.scan_code);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.scan_code !== e) begin
          n_bad++;
          $display("FAIL scan_code got=%h expected=%h", bus.scan_code, e);
        end
      end
    end
    if (bus.frame_err) begin
      err_cnt++;
      n_cmp++;
      if (err_exp == 0) begin
        n_bad++;
        $display("FAIL frame_err_unexpected got=1 expected=0");
      end else begin
        err_exp--;
      end
    end
    if (bus.key_pulse) begin
      kp_cnt++;
      n_cmp++;
      if (cyc != cv_cyc + 1 || kp_prev) begin
        n_bad++;
        $display("FAIL key_pulse_timing cycle=%0d expected=%0d prev_high=%0b", cyc, cv_cyc + 1, kp_prev);
      end
    end
    kp_prev = bus.key_pulse;
    cyc++;
  end

  task automatic ps2_bit(input logic b);
    bus.ps2_data = b;
    repeat (H) @(negedge clk);
    bus.ps2_clk = 1'b0;
    repeat (H) @(negedge clk);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    if (!bad_par && !bad_stop) exp_q.push_back(b);
    else                       err_exp++;
    par = ~(^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(!bad_stop);
    bus.ps2_data = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    ps2_bit(1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(b[i]);
    bus.ps2_data = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.ascii, bus.scan_code, bus.key_pulse, bus.code_valid, bus.frame_err, bus.caps_led} !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_outputs ascii=%h scan=%h kp=%b cv=%b fe=%b caps=%b expected all 0",
               bus.ascii, bus.scan_code, bus.key_pulse, bus.code_valid, bus.frame_err, bus.caps_led);
    end
  endtask

  task automatic test_single_key();
    logic [7:0] seq [$];
    logic [7:0] exp [$];
    int kp0;
    seq = '{8'h1C, 8'hF0, 8'h1C};
    exp = '{8'h61, 8'h61, 8'h00};
    kp0 = kp_cnt;
    foreach (seq[i]) begin
      send_frame(seq[i], 0, 0);
      n_cmp++;
      if (bus.ascii !== exp[i]) begin
        n_bad++;
        $display("FAIL single_key step%0d ascii=%h expected=%h", i, bus.ascii, exp[i]);
      end
    end
    n_cmp++;
    if (kp_cnt - kp0 != 1) begin
      n_bad++;
      $display("FAIL single_key pulses=%0d expected=1", kp_cnt - kp0);
    end
  endtask

  task automatic test_shift_caps();
    logic [7:0] seq [$];
    logic [7:0] exp [$];
    logic [7:0] cseq [$];
    logic       cexp [$];
    seq = '{8'h12, 8'h1C, 8'hF0, 8'h12, 8'hF0, 8'h1C, 8'h58, 8'hF0, 8'h58, 8'h16,
            8'h12, 8'h16, 8'hF0, 8'h16, 8'hF0, 8'h12, 8'h1C, 8'hF0, 8'h1C};
    exp = '{8'h00, 8'h41, 8'h41, 8'h41, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h31,
            8'h31, 8'h21, 8'h21, 8'h00, 8'h00, 8'h00, 8'h41, 8'h41, 8'h00};
    foreach (seq[i]) begin
      send_frame(seq[i], 0, 0);
      n_cmp++;
      if (bus.ascii !== exp[i] || bus.caps_led !== (i >= 6)) begin
        n_bad++;
        $display("FAIL shift_caps step%0d ascii=%h caps=%b expected ascii=%h caps=%b",
                 i, bus.ascii, bus.caps_led, exp[i], (i >= 6));
      end
    end
    // Caps repeats must not toggle again until released
    cseq = '{8'h58, 8'h58, 8'hF0, 8'h58, 8'h58, 8'hF0, 8'h58};
    cexp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    foreach (cseq[i]) begin
      send_frame(cseq[i], 0, 0);
      n_cmp++;
      if (bus.caps_led !== cexp[i]) begin
        n_bad++;
        $display("FAIL caps_toggle step%0d caps=%b expected=%b", i, bus.caps_led, cexp[i]);
      end
    end
  endtask

  task automatic test_typematic();
    logic [7:0] seq [$];
    logic [7:0] exp [$];
    int kp0;
    seq = '{8'h5A, 8'h5A, 8'h5A, 8'h66, 8'hF0, 8'h5A, 8'hF0, 8'h66};
    exp = '{8'h0D, 8'h0D, 8'h0D, 8'h08, 8'h08, 8'h08, 8'h08, 8'h00};
    kp0 = kp_cnt;
    foreach (seq[i]) begin
      send_frame(seq[i], 0, 0);
      n_cmp++;
      if (bus.ascii !== exp[i]) begin
        n_bad++;
        $display("FAIL typematic step%0d ascii=%h expected=%h", i, bus.ascii, exp[i]);
      end
    end
    n_cmp++;
    if (kp_cnt - kp0 != 4) begin
      n_bad++;
      $display("FAIL typematic pulses=%0d expected=4", kp_cnt - kp0);
    end
  endtask

  task automatic test_bad_frames();
    int e0, c0;
    e0 = err_cnt;
    c0 = cv_cnt;
    send_frame(8'h29, 1, 0);
    send_frame(8'h29, 0, 1);
    err_exp++;
    send_partial(8'h29, 4);
    repeat (TO + 50) @(negedge clk);
    n_cmp++;
    if (err_cnt - e0 != 3 || cv_cnt != c0 || bus.ascii !== 8'h00) begin
      n_bad++;
      $display("FAIL bad_frames errs=%0d valids=%0d ascii=%h expected errs=3 valids=0 ascii=00",
               err_cnt - e0, cv_cnt - c0, bus.ascii);
    end
    send_frame(8'h29, 0, 0);
    n_cmp++;
    if (bus.ascii !== 8'h20) begin
      n_bad++;
      $display("FAIL after_bad ascii=%h expected=20", bus.ascii);
    end
    send_frame(8'hF0, 0, 0);
    send_frame(8'h29, 0, 0);
    n_cmp++;
    if (bus.ascii !== 8'h00) begin
      n_bad++;
      $display("FAIL after_bad_release ascii=%h expected=00", bus.ascii);
    end
  endtask

  task automatic test_extended();
    logic [7:0] seq [$];
    int kp0;
    kp0 = kp_cnt;
    send_frame(8'h1C, 0, 0);
    seq = '{8'hAA, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hE0, 8'hF0, 8'h1C};
    foreach (seq[i]) begin
      send_frame(seq[i], 0, 0);
      n_cmp++;
      if (bus.ascii !== 8'h41) begin
        n_bad++;
        $display("FAIL extended step%0d ascii=%h expected=41", i, bus.ascii);
      end
    end
    n_cmp++;
    if (kp_cnt - kp0 != 1) begin
      n_bad++;
      $display("FAIL extended pulses=%0d expected=1", kp_cnt - kp0);
    end
  endtask

  task automatic test_reset_mid_frame();
    send_partial(8'h1C, 4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.ascii, bus.scan_code, bus.key_pulse, bus.code_valid, bus.frame_err, bus.caps_led} !== 20'h0) begin
      n_bad++;
      $display("FAIL mid_reset ascii=%h scan=%h kp=%b cv=%b fe=%b caps=%b expected all 0",
               bus.ascii, bus.scan_code, bus.key_pulse, bus.code_valid, bus.frame_err, bus.caps_led);
    end
    repeat (TO + 50) @(negedge clk);
    send_frame(8'h1C, 0, 0);
    n_cmp++;
    if (bus.ascii !== 8'h61) begin
      n_bad++;
      $display("FAIL post_reset ascii=%h expected=61", bus.ascii);
    end
  endtask

  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    test_reset();
    test_single_key();
    test_shift_caps();
    test_typematic();
    test_bad_frames();
    test_extended();
    test_reset_mid_frame();
    repeat (10) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0 || err_exp != 0) begin
      n_bad++;
      $display("FAIL outstanding bytes=%0d errs=%0d expected 0/0", exp_q.size(), err_exp);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
